// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone classic round-robin arbiter for one shared slave
// Optional watchdog compiled in with WB_ARB_WATCHDOG_EN; default build omits it.
module wb_arbiter2 #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_WIDTH-1:0]   s_adr_o,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  output logic [DAT_WIDTH/8-1:0] s_sel_o,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [1:0]             gnt_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_next;
  logic   last, last_next;
  logic   abort;

  logic                   sel_cyc, sel_stb, sel_we;
  logic [ADR_WIDTH-1:0]   sel_adr;
  logic [DAT_WIDTH-1:0]   sel_dat;
  logic [DAT_WIDTH/8-1:0] sel_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Grant is held for the whole cyc; release hands over directly when the other master waits.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_next  = 1'b0;
          state_next = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_next  = 1'b1;
          state_next = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    case (state)
      GNT0: begin
        sel_cyc = m0_cyc_i;
        sel_stb = m0_stb_i;
        sel_we  = m0_we_i;
        sel_adr = m0_adr_i;
        sel_dat = m0_dat_i;
        sel_sel = m0_sel_i;
      end
      GNT1: begin
        sel_cyc = m1_cyc_i;
        sel_stb = m1_stb_i;
        sel_we  = m1_we_i;
        sel_adr = m1_adr_i;
        sel_dat = m1_dat_i;
        sel_sel = m1_sel_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [15:0] wd_cnt;
  logic        timeout_q;

  assign abort = (state != IDLE) && sel_stb && (wd_cnt == TO_LIMIT);

  // Counts consecutive unanswered strobes under one grant; any answer, gap or regrant restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (abort) timeout_q <= 1'b1;
      if (state == IDLE || state_next != state || !sel_stb || s_ack_i || s_err_i || abort)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign abort     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign s_cyc_o = sel_cyc & ~abort;
  assign s_stb_o = sel_stb & ~abort;
  assign s_we_o  = sel_we;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;
  assign s_sel_o = sel_sel;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == GNT0) & s_ack_i & ~abort;
  assign m1_ack_o = (state == GNT1) & s_ack_i & ~abort;
  assign m0_err_o = (state == GNT0) & (s_err_i | abort);
  assign m1_err_o = (state == GNT1) & (s_err_i | abort);

  assign gnt_o = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2 against a grant-owner reference model
// Build with or without WB_ARB_WATCHDOG_EN; the watchdog steps follow the macro.
module tb_wb_arbiter2;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [1:0]  gnt_o;

  int checks = 0;
  int failures = 0;

  // Reference state: which master owns the slave (-1 none), who was served last, watchdog run length.
  int owner;
  int last_m;
  int wrun;
  bit to_m;

  wb_arbiter2 #(.ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  function automatic logic cyc_of(int n);  return (n == 1) ? m1_cyc : m0_cyc; endfunction
  function automatic logic stb_of(int n);  return (n == 1) ? m1_stb : m0_stb; endfunction
  function automatic logic we_of(int n);   return (n == 1) ? m1_we  : m0_we;  endfunction
  function automatic logic [31:0] adr_of(int n); return (n == 1) ? m1_adr : m0_adr; endfunction
  function automatic logic [31:0] dat_of(int n); return (n == 1) ? m1_dat : m0_dat; endfunction
  function automatic logic [3:0]  sel_of(int n); return (n == 1) ? m1_sel : m0_sel; endfunction

  function automatic bit abort_m();
`ifdef WB_ARB_WATCHDOG_EN
    return (owner >= 0) && stb_of(owner) && (wrun == TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  prev;
    bit  ab;
    prev = owner;
    ab   = abort_m();
    if (reset) begin
      owner = -1; last_m = 1; wrun = 0; to_m = 1'b0;
      return;
    end
    if (ab) to_m = 1'b1;
    if (owner < 0) begin
      if (m0_cyc && m1_cyc) owner = 1 - last_m;
      else if (m0_cyc)      owner = 0;
      else if (m1_cyc)      owner = 1;
    end else if (!cyc_of(owner)) begin
      last_m = owner;
      owner  = cyc_of(1 - owner) ? 1 - owner : -1;
    end
    if (prev < 0 || owner != prev || ab || !stb_of(prev) || s_ack || s_err) wrun = 0;
    else wrun++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check_all();
    int   o;
    bit   ab;
    logic [1:0] eg;
    #1;
    o  = owner;
    ab = abort_m();
    eg = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
    chk("gnt_o",     gnt_o,   eg);
    chk("s_cyc_o",   s_cyc_o, (o >= 0) ? (cyc_of(o) & ~ab) : 1'b0);
    chk("s_stb_o",   s_stb_o, (o >= 0) ? (stb_of(o) & ~ab) : 1'b0);
    chk("s_we_o",    s_we_o,  (o >= 0) ? we_of(o)  : 1'b0);
    chk("s_adr_o",   s_adr_o, (o >= 0) ? adr_of(o) : 32'h0);
    chk("s_dat_o",   s_dat_o, (o >= 0) ? dat_of(o) : 32'h0);
    chk("s_sel_o",   s_sel_o, (o >= 0) ? sel_of(o) : 4'h0);
    chk("m0_ack_o",  m0_ack_o, (o == 0) & s_ack & ~ab);
    chk("m1_ack_o",  m1_ack_o, (o == 1) & s_ack & ~ab);
    chk("m0_err_o",  m0_err_o, (o == 0) & (s_err | ab));
    chk("m1_err_o",  m1_err_o, (o == 1) & (s_err | ab));
    chk("m0_dat_o",  m0_dat_o, s_dat_i);
    chk("m1_dat_o",  m1_dat_o, s_dat_i);
    chk("timeout_o", timeout_o, to_m);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
    s_ack = 0; s_err = 0; s_dat_i = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  rounds, n0, n1, errs, err_at;
    bit  drop0, drop1, term;
    logic [1:0] g_prev;

    owner = -1; last_m = 1; wrun = 0; to_m = 1'b0;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_all();
    reset = 1'b0;

    // Single m0 read.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h7000_0004; m0_sel = 4'hF;
    check_all();
    chk("rd_gnt_before", gnt_o, 2'b00);
    tick();
    chk("rd_gnt_after1", gnt_o, 2'b01);
    s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
    check_all();
    chk("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m0_ack", m0_ack_o, 1'b1);
    chk("rd_m1_ack", m1_ack_o, 1'b0);
    tick();
    idle_inputs();
    check_all();
    tick();

    // Tie after reset goes to m0, then handover without a bubble.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    check_all();
    tick();
    chk("tie_first_m0", gnt_o, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    check_all();
    chk("drop_s_cyc_low", s_cyc_o, 1'b0);
    tick();
    chk("handover_m1", gnt_o, 2'b10);
    m1_cyc = 0; m1_stb = 0;
    check_all();
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    check_all();
    tick();
    chk("rr_after_m1", gnt_o, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    check_all();
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    check_all();
    tick();
    chk("rr_after_m0", gnt_o, 2'b10);

    // m1 write while m0 waits.
    m1_we = 1; m1_dat = 32'h1234_5678; m1_sel = 4'hF; m1_adr = 32'h0000_0100;
    m0_we = 0; m0_dat = 32'hFFFF_0000; m0_sel = 4'h3;
    s_ack = 1;
    check_all();
    chk("wr_s_dat", s_dat_o, 32'h1234_5678);
    chk("wr_s_sel", s_sel_o, 4'hF);
    chk("wr_s_we",  s_we_o,  1'b1);
    chk("wr_m0_ack", m0_ack_o, 1'b0);
    tick();
    idle_inputs();
    check_all();
    tick();

    // Randomized contention: each master drops cyc for one cycle after every termination.
    do_reset();
    drop0 = 0; drop1 = 0; rounds = 0; n0 = 0; n1 = 0; g_prev = 2'b00;
    for (int c = 0; c < 3000 && rounds < 100; c++) begin
      m0_cyc = !drop0; m0_stb = !drop0; m0_we = 1'($urandom);
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom);
      m1_cyc = !drop1; m1_stb = !drop1; m1_we = 1'($urandom);
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom);
      s_ack = ($urandom_range(0, 2) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_dat_i = $urandom;
      check_all();
      term  = (owner >= 0) && stb_of(owner) && (s_ack || s_err || abort_m());
      drop0 = term && (owner == 0);
      drop1 = term && (owner == 1);
      if (term) rounds++;
      tick();
      if (gnt_o != g_prev && gnt_o == 2'b01) n0++;
      if (gnt_o != g_prev && gnt_o == 2'b10) n1++;
      g_prev = gnt_o;
    end
    chk("rr_rounds_done", rounds >= 100, 1'b1);
    chk("rr_balance", (n0 - n1 <= 1) && (n1 - n0 <= 1), 1'b1);
    chk("rr_m1_served", n1 >= 45, 1'b1);

    // Slave that never answers.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
    check_all();
    tick();
    errs = 0; err_at = 0;
    for (int k = 1; k <= 20; k++) begin
      check_all();
      if (m0_err_o === 1'b1) begin
        errs++;
        if (err_at == 0) err_at = k;
        m0_cyc = 0; m0_stb = 0;
      end
      tick();
    end
    check_all();
`ifdef WB_ARB_WATCHDOG_EN
    chk("wd_err_once", errs, 1);
    chk("wd_err_cycle", err_at, 5);
    chk("wd_timeout_sticky", timeout_o, 1'b1);
`else
    chk("nowd_err_none", errs, 0);
    chk("nowd_timeout_low", timeout_o, 1'b0);
`endif
    idle_inputs();

    // Reset in the middle of an m1 transfer.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
    check_all();
    tick();
    chk("mid_gnt_m1", gnt_o, 2'b10);
    reset = 1'b1;
    check_all();
    tick();
    s_ack = 1;
    check_all();
    chk("mid_rst_gnt", gnt_o, 2'b00);
    chk("mid_rst_s_cyc", s_cyc_o, 1'b0);
    chk("mid_rst_m1_ack", m1_ack_o, 1'b0);
    reset = 1'b0;
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    check_all();
    tick();
    chk("post_rst_tie_m0", gnt_o, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
